// File: rtl/seg7_scan_pager_if.sv
// Bus between a controller and the seven-segment scan pager.
// Handshake: there is no valid/ready pair. wr_en is a single-cycle write strobe
// that is always accepted (no backpressure); wr_page/wr_digit/wr_data are
// qualified by wr_en in the same cycle. page is a level that the pager samples
// only at frame boundaries. seg/dig_sel/page_shown are registered outputs.
interface seg7_scan_pager_if #(
  parameter int DIGITS = 4,
  parameter int AW     = $clog2(DIGITS)
);
  logic              page;
  logic              wr_en;
  logic              wr_page;
  logic [AW-1:0]     wr_digit;
  logic [3:0]        wr_data;
  logic [6:0]        seg;
  logic [DIGITS-1:0] dig_sel;
  logic              page_shown;

  modport master (
    output page, wr_en, wr_page, wr_digit, wr_data,
    input  seg, dig_sel, page_shown
  );

  modport slave (
    input  page, wr_en, wr_page, wr_digit, wr_data,
    output seg, dig_sel, page_shown
  );
endinterface

// File: rtl/seg7_scan_pager.sv
// Multiplexed seven-segment driver with two pages of BCD digit storage.
// A prescaler sets the slot length; the scan index walks the digits and the
// displayed page is only switched at a frame boundary so a frame never mixes
// digits from both pages. seg/dig_sel lag the scan state by one cycle.
module seg7_scan_pager #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 50000,
  parameter int AW      = $clog2(DIGITS)
) (
  input logic              clk,
  input logic              rst_n,
  seg7_scan_pager_if.slave bus
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] DIV_LAST  = PW'(CLK_DIV - 1);
  localparam logic [AW-1:0] SCAN_LAST = AW'(DIGITS - 1);
  localparam logic [AW:0]   DIGITS_W  = (AW + 1)'(DIGITS);

  logic [PW-1:0]     presc;
  logic [AW-1:0]     scan_idx;
  logic              page_q;
  logic [3:0]        mem [2][DIGITS];
  logic [6:0]        seg_q;
  logic [DIGITS-1:0] dig_q;
  logic              tick;
  logic              wr_ok;

  assign tick  = (presc == DIV_LAST);
  // Out-of-range digit addresses are dropped rather than aliased.
  assign wr_ok = bus.wr_en && ({1'b0, bus.wr_digit} < DIGITS_W);

  // BCD to abcdefg; codes 10..15 blank the digit.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    s = 7'b0000000;
    case (v)
      4'd0: s = 7'b1111110;
      4'd1: s = 7'b0110000;
      4'd2: s = 7'b1101101;
      4'd3: s = 7'b1111001;
      4'd4: s = 7'b0110011;
      4'd5: s = 7'b1011011;
      4'd6: s = 7'b1011111;
      4'd7: s = 7'b1110000;
      4'd8: s = 7'b1111111;
      4'd9: s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Prescaler, scan index and frame-boundary page latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      scan_idx <= '0;
      page_q   <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        if (scan_idx == SCAN_LAST) begin
          scan_idx <= '0;
          page_q   <= bus.page;
        end else begin
          scan_idx <= scan_idx + 1'b1;
        end
      end
    end
  end

  // Digit storage; reset fills every entry with the blank code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        for (int d = 0; d < DIGITS; d++) begin
          mem[p][d] <= 4'hF;
        end
      end
    end else if (wr_ok) begin
      mem[bus.wr_page][bus.wr_digit] <= bus.wr_data;
    end
  end

  // Registered display outputs built from last cycle's scan state and storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 7'b0000000;
      dig_q <= '0;
    end else begin
      seg_q <= decode(mem[page_q][scan_idx]);
      dig_q <= DIGITS'(1) << scan_idx;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig_sel    = dig_q;
  assign bus.page_shown = page_q;

endmodule

// File: tb/tb_seg7_scan_pager.sv
// Directed bench for seg7_scan_pager with DIGITS=4/CLK_DIV=4, plus a
// DIGITS=3 instance for the out-of-range write address case.
module tb_seg7_scan_pager;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_scan_pager_if #(.DIGITS(4)) bus ();
  seg7_scan_pager_if #(.DIGITS(3)) bus3 ();

  seg7_scan_pager #(.DIGITS(4), .CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  seg7_scan_pager #(.DIGITS(3), .CLK_DIV(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  // Scoreboard counters
  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] val;
    logic [6:0] seg;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for the start of a fresh slot showing the given digit.
  task automatic wait_new(input logic [3:0] mask);
    int n;
    n = 0;
    while (bus.dig_sel == mask && n < 40) begin step(); n++; end
    while (bus.dig_sel != mask && n < 40) begin step(); n++; end
    if (bus.dig_sel != mask) begin
      n_total++;
      $display("FAIL wait_dig: timeout waiting for dig_sel %b", mask);
    end
  endtask

  task automatic wr(input logic pg, input logic [1:0] d, input logic [3:0] v);
    bus.wr_en    = 1'b1;
    bus.wr_page  = pg;
    bus.wr_digit = d;
    bus.wr_data  = v;
    step();
    bus.wr_en    = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_dig;
    tbl[0]  = '{4'd0,  7'b1111110};
    tbl[1]  = '{4'd1,  7'b0110000};
    tbl[2]  = '{4'd2,  7'b1101101};
    tbl[3]  = '{4'd3,  7'b1111001};
    tbl[4]  = '{4'd4,  7'b0110011};
    tbl[5]  = '{4'd5,  7'b1011011};
    tbl[6]  = '{4'd6,  7'b1011111};
    tbl[7]  = '{4'd7,  7'b1110000};
    tbl[8]  = '{4'd8,  7'b1111111};
    tbl[9]  = '{4'd9,  7'b1111011};
    tbl[10] = '{4'd10, 7'b0000000};
    tbl[11] = '{4'd11, 7'b0000000};
    tbl[12] = '{4'd12, 7'b0000000};
    tbl[13] = '{4'd13, 7'b0000000};
    tbl[14] = '{4'd14, 7'b0000000};
    tbl[15] = '{4'd15, 7'b0000000};

    bus.page = 1'b0; bus.wr_en = 1'b0; bus.wr_page = 1'b0;
    bus.wr_digit = '0; bus.wr_data = '0;
    bus3.page = 1'b0; bus3.wr_en = 1'b0; bus3.wr_page = 1'b0;
    bus3.wr_digit = '0; bus3.wr_data = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_seg", 32'(bus.seg), 32'h0);
    check("rst_dig", 32'(bus.dig_sel), 32'h0);
    check("rst_page_shown", 32'(bus.page_shown), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Free-running scan after reset, nothing written.
    for (int k = 1; k <= 17; k++) begin
      step();
      exp_dig = 4'b0001 << (((k - 1) / 4) % 4);
      check("scan_dig", 32'(bus.dig_sel), 32'(exp_dig));
      check("scan_seg_blank", 32'(bus.seg), 32'h0);
    end

    // Decode table: write into the digit on screen, seen one cycle later.
    for (int i = 0; i < 16; i++) begin
      wait_new(4'b0100);
      wr(1'b0, 2'd2, tbl[i].val);
      step();
      check("live_dig", 32'(bus.dig_sel), 32'h4);
      check("decode_seg", 32'(bus.seg), 32'(tbl[i].seg));
    end

    // Fill both pages.
    wr(1'b0, 2'd0, 4'd1); wr(1'b0, 2'd1, 4'd2);
    wr(1'b0, 2'd2, 4'd3); wr(1'b0, 2'd3, 4'd4);
    wr(1'b1, 2'd0, 4'd9); wr(1'b1, 2'd1, 4'd8);
    wr(1'b1, 2'd2, 4'd7); wr(1'b1, 2'd3, 4'd6);

    // Page 0 frame shows 1,2,3,4.
    wait_new(4'b0001);
    check("p0_dig0", 32'(bus.seg), 32'(7'b0110000));
    for (int j = 1; j < 4; j++) begin
      repeat (4) step();
      check("p0_dig", 32'(bus.dig_sel), 32'(4'b0001 << j));
      check("p0_seg", 32'(bus.seg), 32'(tbl[j + 1].seg));
    end

    // Page switch requested mid-frame takes effect at the boundary.
    wait_new(4'b0010);
    bus.page = 1'b1;
    check("sw_dig1", 32'(bus.seg), 32'(7'b1101101));
    repeat (4) step();
    check("sw_dig2", 32'(bus.seg), 32'(7'b1111001));
    repeat (4) step();
    check("sw_dig3", 32'(bus.seg), 32'(7'b0110011));
    check("sw_shown_old", 32'(bus.page_shown), 32'h0);
    repeat (4) step();
    check("sw_new_dig", 32'(bus.dig_sel), 32'h1);
    check("sw_new_seg", 32'(bus.seg), 32'(7'b1111011));
    check("sw_shown_new", 32'(bus.page_shown), 32'h1);
    repeat (4) step();
    check("p1_dig1", 32'(bus.seg), 32'(7'b1111111));

    // Brief glitch on page away from the boundary is ignored.
    bus.page = 1'b0;
    repeat (4) step();
    check("p1_dig2", 32'(bus.seg), 32'(7'b1110000));
    bus.page = 1'b1;
    repeat (4) step();
    check("p1_dig3", 32'(bus.seg), 32'(7'b1011111));
    repeat (4) step();
    check("glitch_shown", 32'(bus.page_shown), 32'h1);
    check("glitch_seg", 32'(bus.seg), 32'(7'b1111011));

    // Live write to shown page 1, digit 2.
    wait_new(4'b0100);
    wr(1'b1, 2'd2, 4'd5);
    step();
    check("live_p1_seg", 32'(bus.seg), 32'(7'b1011011));

    // Asynchronous reset mid-frame with page 1 shown.
    wait_new(4'b0100);
    #3 rst_n = 1'b0;
    #1;
    check("arst_seg", 32'(bus.seg), 32'h0);
    check("arst_dig", 32'(bus.dig_sel), 32'h0);
    check("arst_page_shown", 32'(bus.page_shown), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("rel_dig", 32'(bus.dig_sel), 32'h1);
    check("rel_seg", 32'(bus.seg), 32'h0);
    check("rel_page_shown", 32'(bus.page_shown), 32'h0);
    for (int k = 2; k <= 33; k++) begin
      step();
      check("rel_blank", 32'(bus.seg), 32'h0);
    end
    check("rel_page_later", 32'(bus.page_shown), 32'h1);

    // DIGITS=3 instance: address 3 is out of range, digit 2 is valid.
    bus3.wr_en = 1'b1; bus3.wr_page = 1'b0;
    bus3.wr_digit = 2'd3; bus3.wr_data = 4'd1;
    step();
    bus3.wr_digit = 2'd2; bus3.wr_data = 4'd7;
    step();
    bus3.wr_en = 1'b0;
    for (int k = 0; k < 24; k++) begin
      step();
      check("d3_onehot", 32'($onehot(bus3.dig_sel)), 32'h1);
      if (bus3.dig_sel == 3'b100) check("d3_dig2", 32'(bus3.seg), 32'(7'b1110000));
      else check("d3_blank", 32'(bus3.seg), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg7_scan_pager.md
SEG7_SCAN_PAGER -- requirements
Module: seg7_scan_pager

Parameters
REQ-001 DIGITS, default 4, number of multiplexed digits, legal range 2..8.
REQ-002 CLK_DIV, default 50000, clock cycles per digit slot, legal range >= 2.
REQ-003 AW, default clog2(DIGITS), width of the digit address.

Interface
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- page  in  1  requested display page; 0 = page 0, 1 = page 1.
- wr_en  in  1  write strobe for one BCD digit.
- wr_page  in  1  target page of the write.
- wr_digit  in  AW  target digit index of the write.
- wr_data  in  4  BCD value to store.
- seg  out  7  segment drive {a,b,c,d,e,f,g}, active-high; a is the top bar, b..f follow clockwise, g is the middle bar.
- dig_sel  out  DIGITS  one-hot digit enable, active-high; bit i = digit i.
- page_shown  out  1  page currently being displayed.

Function
REQ-005 The block SHALL hold a storage array of 2 pages x DIGITS entries x 4 bits.
REQ-006 When wr_en=1 and wr_digit<DIGITS, the block SHALL write wr_data to [wr_page][wr_digit] at the clock edge; when wr_digit>=DIGITS the write SHALL be ignored.
REQ-007 A prescaler SHALL count 0..CLK_DIV-1 and wrap; tick SHALL be asserted in the cycle the prescaler equals CLK_DIV-1.
REQ-008 The scan index SHALL advance by 1 on each tick and wrap from DIGITS-1 to 0.
REQ-009 page_shown SHALL load page only on a tick while the scan index equals DIGITS-1, so a page change takes effect only at a frame boundary.
REQ-010 Toggling page mid-frame SHALL NOT alter the digits of the current frame; only the value of page sampled at the boundary tick counts.
REQ-011 seg and dig_sel SHALL be registered and SHALL reflect the scan index, page_shown and array contents of the previous cycle (1-cycle latency).
REQ-012 The decode SHALL map each 4-bit value to abcdefg as follows:
- 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
- 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- 10..15=0000000 (blank)
REQ-013 dig_sel SHALL have exactly one bit set in every cycle after the first post-reset edge, namely bit (scan index).
REQ-014 A write to the digit and page currently displayed SHALL appear on seg one cycle after the write edge, without waiting for the next frame.
REQ-015 A write coincident with a tick or with a page switch SHALL be committed; the displayed value SHALL follow REQ-011 using the post-edge state.

Reset
REQ-016 While rst_n=0, the block SHALL asynchronously force the following state:
- prescaler=0, scan index=0, page_shown=0
- seg=0000000, dig_sel=all zero
- all array entries=4'hF (blank)
REQ-017 On the first rising edge after rst_n deasserts, the block SHALL drive dig_sel=...0001 and seg=0000000.
REQ-018 A reset asserted mid-frame SHALL discard the frame position, page_shown and all stored digits.

Verification (DIGITS=4, CLK_DIV=4)
REQ-019 Reset release, no writes -> dig_sel sequence 0001,0010,0100,1000,0001 with 4 cycles per step; seg=0000000 throughout.
REQ-020 Write page0 digits 0..3 = 1,2,3,4, page=0 -> each slot i shows its pattern; digit0 shows 0110000 and digit1 shows 1101101.
REQ-021 Page1 filled with 9,8,7,6; toggle page to 1 while dig_sel=0010 -> digits 1..3 still show 2,3,4; the next frame starts at digit0 with 1111011 and page_shown=1.
REQ-022 While digit2 of the shown page is displayed, write wr_data=5 -> seg=1011011 one cycle after the write edge.
REQ-023 Write wr_data=12 to a digit -> blank (0000000); write with wr_digit=3 when DIGITS=3 -> array unchanged.
REQ-024 Assert rst_n=0 mid-frame with page_shown=1 -> seg, dig_sel and page_shown go to 0 immediately without a clock edge; all digits are blank after release.
